// File: rtl/traceback_pkg.sv
// ============================================================================
// Module   : traceback_pkg
// Purpose  : Shared types and the source-to-op decode for the traceback unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package traceback_pkg;

    typedef enum logic [1:0] {
        SRC_DIAG0 = 2'b00,
        SRC_LEFT  = 2'b01,
        SRC_DIAG1 = 2'b10,
        SRC_TOP   = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        OP_MATCH = 2'b00,
        OP_DEL   = 2'b01,
        OP_INS   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } tb_state_e;

    // Both diagonal encodings collapse onto the single match/mismatch op.
    function automatic op_e src_to_op(input src_e src);
        case (src)
            SRC_LEFT: return OP_DEL;
            SRC_TOP:  return OP_INS;
            default:  return OP_MATCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tb_coord_step.sv
// ============================================================================
// Module   : tb_coord_step
// Purpose  : Combinational next-coordinate and array-edge detect for one op.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_coord_step
    import traceback_pkg::*;
#(
    parameter int COORD_W = 5
) (
    input  logic [COORD_W-1:0] cur_row,
    input  logic [COORD_W-1:0] cur_col,
    input  op_e                op,
    output logic [COORD_W-1:0] next_row,
    output logic [COORD_W-1:0] next_col,
    output logic               out_of_bounds
);

    logic w_row_dec;
    logic w_col_dec;

    always_comb begin
        w_row_dec     = (op != OP_DEL);
        w_col_dec     = (op != OP_INS);
        next_row      = w_row_dec ? (cur_row - COORD_W'(1)) : cur_row;
        next_col      = w_col_dec ? (cur_col - COORD_W'(1)) : cur_col;
        out_of_bounds = (w_row_dec && (cur_row == '0)) ||
                        (w_col_dec && (cur_col == '0));
    end

endmodule

`default_nettype wire

// File: rtl/traceback_unit.sv
// ============================================================================
// Module   : traceback_unit
// Purpose  : Walks stored source codes from the best cell back to the origin,
//            streaming one alignment op per visited cell. Optional op_score
//            output is enabled by defining TRACEBACK_SCORE_OUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module traceback_unit
    import traceback_pkg::*;
#(
    parameter int SCORE_WIDTH_MAX = 7,
    parameter int SEQ_LEN         = 32,
    parameter int COORD_W         = $clog2(SEQ_LEN),
    parameter int LEN_W           = $clog2(2*SEQ_LEN+1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [COORD_W-1:0]         start_row,
    input  logic [COORD_W-1:0]         start_col,
    output logic                       busy,
    output logic                       done,
    output logic [LEN_W-1:0]           path_len,
    output logic                       mem_rd_en,
    output logic [2*COORD_W-1:0]       mem_rd_addr,
    input  logic [SCORE_WIDTH_MAX+1:0] mem_rd_data,
    output logic                       op_valid,
    input  logic                       op_ready,
`ifdef TRACEBACK_SCORE_OUT_EN
    output logic [SCORE_WIDTH_MAX-1:0] op_score,
`endif
    output logic [1:0]                 op_code
);

    tb_state_e                  r_state;
    tb_state_e                  w_state_nxt;
    logic [COORD_W-1:0]         r_row;
    logic [COORD_W-1:0]         r_col;
    logic [COORD_W-1:0]         w_next_row;
    logic [COORD_W-1:0]         w_next_col;
    logic                       w_oob;
    op_e                        r_op;
    logic [LEN_W-1:0]           r_len;
    logic [SCORE_WIDTH_MAX-1:0] w_score;
    src_e                       w_src;
    logic                       w_score_zero;

    assign w_score      = mem_rd_data[SCORE_WIDTH_MAX+1:2];
    assign w_src        = src_e'(mem_rd_data[1:0]);
    assign w_score_zero = (w_score == '0);
    assign path_len     = r_len;

    tb_coord_step #(
        .COORD_W (COORD_W)
    ) u_coord_step (
        .cur_row       (r_row),
        .cur_col       (r_col),
        .op            (r_op),
        .next_row      (w_next_row),
        .next_col      (w_next_col),
        .out_of_bounds (w_oob)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        op_valid    = 1'b0;
        op_code     = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = {r_row, r_col};
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                w_state_nxt = w_score_zero ? S_FIN : S_EMIT;
            end
            S_EMIT: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                op_code  = r_op;
                if (op_ready) begin
                    w_state_nxt = w_oob ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Coordinates advance only on an accepted op, so a stall never re-reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
            r_op  <= OP_MATCH;
            r_len <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row <= start_row;
                        r_col <= start_col;
                        r_len <= '0;
                    end
                end
                S_WAIT: begin
                    if (!w_score_zero) begin
                        r_op <= src_to_op(w_src);
                    end
                end
                S_EMIT: begin
                    if (op_ready) begin
                        r_len <= r_len + LEN_W'(1);
                        if (!w_oob) begin
                            r_row <= w_next_row;
                            r_col <= w_next_col;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRACEBACK_SCORE_OUT_EN
    logic [SCORE_WIDTH_MAX-1:0] r_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_score <= '0;
        end else if ((r_state == S_WAIT) && !w_score_zero) begin
            r_score <= w_score;
        end
    end

    assign op_score = op_valid ? r_score : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_traceback_unit.sv
// ============================================================================
// Module   : tb_traceback_unit
// Purpose  : Directed self-checking bench for traceback_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_traceback_unit;

    localparam int SW      = 7;
    localparam int SEQ_LEN = 32;
    localparam int CW      = 5;
    localparam int LW      = 7;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [CW-1:0] start_row = '0;
    logic [CW-1:0] start_col = '0;
    logic          op_ready  = 1'b1;
    logic [SW+1:0] mem_rd_data = '0;
    wire           busy;
    wire           done;
    wire  [LW-1:0] path_len;
    wire           mem_rd_en;
    wire [2*CW-1:0] mem_rd_addr;
    wire           op_valid;
    wire  [1:0]    op_code;
`ifdef TRACEBACK_SCORE_OUT_EN
    wire  [SW-1:0] op_score;
`endif

    logic [SW+1:0]   mem [0:1023];
    logic [2*CW-1:0] rd_log [$];
    logic [1:0]      op_log [$];
    int              score_log [$];
    int              valid_seen = 0;
    int              errors = 0;
    int              checks = 0;

    always #5 clk = ~clk;

    traceback_unit #(
        .SCORE_WIDTH_MAX (SW),
        .SEQ_LEN         (SEQ_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_row   (start_row),
        .start_col   (start_col),
        .busy        (busy),
        .done        (done),
        .path_len    (path_len),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
`ifdef TRACEBACK_SCORE_OUT_EN
        .op_score    (op_score),
`endif
        .op_code     (op_code)
    );

    // Cell store with one-cycle read latency plus transaction logging.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_log.push_back(mem_rd_addr);
        end
        if (op_valid) valid_seen <= valid_seen + 1;
        if (op_valid && op_ready) begin
            op_log.push_back(op_code);
`ifdef TRACEBACK_SCORE_OUT_EN
            score_log.push_back(int'(op_score));
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int r, input int c);
        @(negedge clk);
        start_row = CW'(r);
        start_col = CW'(c);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called at the negedge right after start drops (cycle 1 = RD).
    task automatic wait_done(output int k);
        k = 1;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic check_idle_after(input string tag, input int len);
        @(negedge clk);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_len_held"}, path_len, len);
    endtask

    // Main four-op walk; the zero cell at (0,0) terminates it after a 5th read.
    task automatic check_s1(input string tag, input int rb, input int ob, input int sb);
        int exp_rd [5] = '{99, 66, 33, 32, 0};
        int exp_op [4] = '{0, 0, 1, 3};
        int exp_sc [4] = '{5, 4, 2, 1};
        check({tag, "_len"}, path_len, 4);
        check({tag, "_nrd"}, rd_log.size() - rb, 5);
        check({tag, "_nop"}, op_log.size() - ob, 4);
        for (int i = 0; i < 5; i++) check({tag, "_rd_addr"}, rd_log[rb+i], exp_rd[i]);
        for (int i = 0; i < 4; i++) check({tag, "_op_code"}, op_log[ob+i], exp_op[i]);
`ifdef TRACEBACK_SCORE_OUT_EN
        for (int i = 0; i < 4; i++) check({tag, "_op_score"}, score_log[sb+i], exp_sc[i]);
`else
        if (sb < 0) check({tag, "_sb"}, sb, 0);
`endif
    endtask

    initial begin
        int k, rb, ob, sb, vb, t, nr;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[3*32+3] = {7'd5, 2'b00};
        mem[2*32+2] = {7'd4, 2'b10};
        mem[1*32+1] = {7'd2, 2'b01};
        mem[1*32+0] = {7'd1, 2'b11};
        mem[7*32+7] = {7'd6, 2'b00};
        mem[2*32+0] = {7'd1, 2'b01};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_len", path_len, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_valid", op_valid, 0);
        check("rst_code", op_code, 0);

        // Basic walk with op_ready held high.
        rb = rd_log.size(); ob = op_log.size(); sb = score_log.size();
        pulse_start(3, 3);
        check("s1_busy", busy, 1);
        check("s1_rd_en", mem_rd_en, 1);
        wait_done(k);
        check("s1_done_cycle", k, 15);
        check_s1("s1", rb, ob, sb);
        check_idle_after("s1", 4);

        // Zero-score start cell.
        rb = rd_log.size(); vb = valid_seen;
        pulse_start(4, 2);
        wait_done(k);
        check("zero_done_cycle", k, 3);
        check("zero_len", path_len, 0);
        check("zero_no_valid", valid_seen - vb, 0);
        check("zero_nrd", rd_log.size() - rb, 1);

        // Origin cell with nonzero score.
        mem[0] = {7'd3, 2'b00};
        rb = rd_log.size(); ob = op_log.size();
        pulse_start(0, 0);
        wait_done(k);
        check("org_done_cycle", k, 4);
        check("org_len", path_len, 1);
        check("org_nrd", rd_log.size() - rb, 1);
        check("org_nop", op_log.size() - ob, 1);
        check("org_op", op_log[ob], 0);
        mem[0] = '0;

        // Left move at column 0 leaves the array.
        rb = rd_log.size(); ob = op_log.size();
        pulse_start(2, 0);
        wait_done(k);
        check("left_edge_len", path_len, 1);
        check("left_edge_nrd", rd_log.size() - rb, 1);
        check("left_edge_op", op_log[ob], 1);

        // Backpressure for five cycles on the second op.
        rb = rd_log.size(); ob = op_log.size(); sb = score_log.size();
        op_ready = 1'b0;
        pulse_start(3, 3);
        t = 0;
        while (!op_valid && t < 20) begin @(negedge clk); t++; end
        check("stall_valid1", op_valid, 1);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        t = 0;
        while (!op_valid && t < 20) begin @(negedge clk); t++; end
        nr = rd_log.size();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid_held", op_valid, 1);
            check("stall_code_held", op_code, 0);
`ifdef TRACEBACK_SCORE_OUT_EN
            check("stall_score_held", op_score, 4);
`endif
            @(negedge clk);
        end
        check("stall_no_reads", rd_log.size(), nr);
        op_ready = 1'b1;
        wait_done(k);
        check_s1("stall", rb, ob, sb);

        // Start re-pulsed while busy is ignored.
        rb = rd_log.size(); ob = op_log.size(); sb = score_log.size();
        pulse_start(3, 3);
        repeat (3) @(negedge clk);
        check("repulse_busy", busy, 1);
        pulse_start(7, 7);
        wait_done(k);
        check("repulse_done_cycle", k, 10);
        check_s1("repulse", rb, ob, sb);
        check_idle_after("repulse", 4);

        // Reset in the middle of a stalled EMIT.
        op_ready = 1'b0;
        pulse_start(3, 3);
        t = 0;
        while (!op_valid && t < 20) begin @(negedge clk); t++; end
        check("rst_mid_valid", op_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_len", path_len, 0);
        check("rst_mid_rd_en", mem_rd_en, 0);
        check("rst_mid_addr", mem_rd_addr, 0);
        check("rst_mid_valid0", op_valid, 0);
        check("rst_mid_code", op_code, 0);
`ifdef TRACEBACK_SCORE_OUT_EN
        check("rst_mid_score", op_score, 0);
`endif
        rst = 1'b0;
        op_ready = 1'b1;
        rb = rd_log.size(); ob = op_log.size(); sb = score_log.size();
        pulse_start(3, 3);
        wait_done(k);
        check("post_rst_done_cycle", k, 15);
        check_s1("post_rst", rb, ob, sb);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
